// File: rtl/boot_copier.sv
// Copies the bootloader ROM image into instruction memory over a valid/ready write port.
// Optional running checksum of the copied image: define BOOT_CHECKSUM_EN.
module boot_copier #(
  parameter int PortSize    = 4,
  parameter int DataSize    = 4,
  parameter int RomLength   = 8,
  parameter int MemAddrSize = 8,
  parameter logic [MemAddrSize-1:0] BaseAddress = '0
`ifdef BOOT_CHECKSUM_EN
  ,
  parameter logic [DataSize-1:0] ExpectedSum = DataSize'(4)
`endif
) (
  input  logic                   Clk,
  input  logic                   Rst,
  input  logic                   Start,
  output logic [PortSize-1:0]    RomAddress,
  input  logic [DataSize-1:0]    RomData,
  output logic [MemAddrSize-1:0] WrAddress,
  output logic [DataSize-1:0]    WrData,
  output logic                   WrEn,
  input  logic                   WrReady,
  output logic                   Busy,
  output logic                   Done
`ifdef BOOT_CHECKSUM_EN
  ,
  output logic [DataSize-1:0]    Checksum,
  output logic                   ChecksumOk
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE,
    FINISH
  } state_t;

  localparam logic [PortSize-1:0] LastAddr =
    PortSize'(RomLength - 1);

  state_t state, state_nxt;
  logic   go;
  logic   fire;
  logic   last;

  assign go   = Start &
    ((state == IDLE) | (state == FINISH));
  assign fire = WrEn & WrReady;
  assign last = (RomAddress == LastAddr);

  assign WrEn = (state == WRITE);
  assign Busy = (state == READ) | (state == WRITE);
  assign Done = (state == FINISH);

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:   if (Start) state_nxt = READ;
      READ:   state_nxt = WRITE;
      WRITE:  if (fire) state_nxt = last ? FINISH : READ;
      FINISH: if (Start) state_nxt = READ;
      default: state_nxt = IDLE;
    endcase
  end

  // Address/data are captured in READ and held until the handshake.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      RomAddress <= '0;
      WrAddress  <= BaseAddress;
      WrData     <= '0;
    end else begin
      if (go) RomAddress <= '0;
      else if (fire && !last)
        RomAddress <= RomAddress + PortSize'(1);
      if (state == READ) begin
        WrData    <= RomData;
        WrAddress <= BaseAddress
          + MemAddrSize'(RomAddress);
      end
    end
  end

`ifdef BOOT_CHECKSUM_EN
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst)       Checksum <= '0;
    else if (go)   Checksum <= '0;
    else if (fire) Checksum <= Checksum + WrData;
  end

  assign ChecksumOk = Done & (Checksum == ExpectedSum);
`endif

endmodule

// File: tb/tb_boot_copier.sv
// Directed bench for boot_copier: copy, stall, ignored restart,
// mid-copy reset, address wrap and (when enabled) checksum.
module tb_boot_copier;

  logic       Clk = 1'b0;
  logic       Rst;
  logic       Start;
  logic       WrReady;
  logic [3:0] ra1, ra2;
  logic [3:0] rd1, rd2;
  logic [7:0] wa1, wa2;
  logic [3:0] wd1, wd2;
  logic       we1, we2;
  logic       busy1, busy2;
  logic       done1, done2;
`ifdef BOOT_CHECKSUM_EN
  logic [3:0] cs1, cs2;
  logic       ok1, ok2;
`endif

  logic [3:0] img [0:7] = '{4'hE, 4'hB, 4'hA, 4'h5,
                            4'h6, 4'h5, 4'hA, 4'h7};

  int checks = 0;
  int errors = 0;

  logic [7:0] qa1[$];
  logic [3:0] qd1[$];
  logic [7:0] qa2[$];

  always #5 Clk = ~Clk;

  assign rd1 = img[ra1[2:0]];
  assign rd2 = img[ra2[2:0]];

  boot_copier dut (
    .Clk(Clk), .Rst(Rst), .Start(Start),
    .RomAddress(ra1), .RomData(rd1),
    .WrAddress(wa1), .WrData(wd1), .WrEn(we1),
    .WrReady(WrReady), .Busy(busy1), .Done(done1)
`ifdef BOOT_CHECKSUM_EN
    , .Checksum(cs1), .ChecksumOk(ok1)
`endif
  );

  boot_copier #(
    .BaseAddress(8'hFC)
`ifdef BOOT_CHECKSUM_EN
    , .ExpectedSum(4'h5)
`endif
  ) dut2 (
    .Clk(Clk), .Rst(Rst), .Start(Start),
    .RomAddress(ra2), .RomData(rd2),
    .WrAddress(wa2), .WrData(wd2), .WrEn(we2),
    .WrReady(WrReady), .Busy(busy2), .Done(done2)
`ifdef BOOT_CHECKSUM_EN
    , .Checksum(cs2), .ChecksumOk(ok2)
`endif
  );

  always @(posedge Clk) begin
    if (we1 && WrReady) begin
      qa1.push_back(wa1);
      qd1.push_back(wd1);
    end
    if (we2 && WrReady) qa2.push_back(wa2);
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic check_log(input int from);
    chk("n_writes", 32'(qa1.size() - from), 32'd8);
    chk("n_writes2", 32'(qa2.size() - from), 32'd8);
    for (int i = 0; i < 8; i++) begin
      if (from + i < qa1.size()) begin
        chk($sformatf("waddr%0d", i),
            32'(qa1[from+i]), 32'(i));
        chk($sformatf("wdata%0d", i),
            32'(qd1[from+i]), 32'(img[i]));
      end
      if (from + i < qa2.size())
        chk($sformatf("wrap_addr%0d", i),
            32'(qa2[from+i]), 32'((8'hFC + i) & 8'hFF));
    end
  endtask

  task automatic run_copy(input  int stall_word,
                          input  int stall_len,
                          input  int restart_at,
                          output int cycles,
                          output int busy_cnt);
    int stalled;
    bit restarted;
    stalled   = 0;
    restarted = 0;
    WrReady   = 1'b1;
    Start     = 1'b1;
    step();
    Start     = 1'b0;
    cycles    = 0;
    busy_cnt  = busy1 ? 1 : 0;
    chk("start_busy", 32'(busy1), 32'd1);
    chk("start_done", 32'(done1), 32'd0);
    chk("start_romaddr", 32'(ra1), 32'd0);
    while (!done1 && cycles < 200) begin
      WrReady = 1'b1;
      if (we1 && ra1 == 4'(stall_word)
          && stalled < stall_len) begin
        WrReady = 1'b0;
        stalled++;
        chk("stall_addr", 32'(wa1), 32'h2);
        chk("stall_data", 32'(wd1), 32'hA);
      end
      if (we1 && ra1 == 4'(restart_at) && !restarted) begin
        Start     = 1'b1;
        restarted = 1'b1;
      end
      step();
      Start = 1'b0;
      cycles++;
      if (busy1) busy_cnt++;
    end
    WrReady = 1'b1;
    chk("done_reached", 32'(done1), 32'd1);
    chk("done_busy_low", 32'(busy1), 32'd0);
    chk("done_wren_low", 32'(we1), 32'd0);
    chk("done_romaddr", 32'(ra1), 32'd7);
`ifdef BOOT_CHECKSUM_EN
    chk("checksum", 32'(cs1), 32'h4);
    chk("checksum_ok", 32'(ok1), 32'd1);
    chk("checksum_ok_exp5", 32'(ok2), 32'd0);
`endif
  endtask

  initial begin
    int cyc, bsy, base;
    bit found;
    Rst     = 1'b1;
    Start   = 1'b0;
    WrReady = 1'b1;
    #3;
    chk("rst_romaddr", 32'(ra1), 32'd0);
    chk("rst_waddr", 32'(wa1), 32'd0);
    chk("rst_waddr_base", 32'(wa2), 32'hFC);
    chk("rst_wdata", 32'(wd1), 32'd0);
    chk("rst_wren", 32'(we1), 32'd0);
    chk("rst_busy", 32'(busy1), 32'd0);
    chk("rst_done", 32'(done1), 32'd0);
`ifdef BOOT_CHECKSUM_EN
    chk("rst_checksum", 32'(cs1), 32'd0);
    chk("rst_checksum_ok", 32'(ok1), 32'd0);
`endif
    step();
    step();
    Rst = 1'b0;
    step();
    chk("idle_busy", 32'(busy1), 32'd0);

    // plain copy
    base = qa1.size();
    run_copy(-1, 0, -1, cyc, bsy);
    chk("latency", 32'(cyc), 32'd16);
    chk("busy_cycles", 32'(bsy), 32'd16);
    check_log(base);
    step();
    chk("done_held", 32'(done1), 32'd1);

    // WrReady held low on third word
    base = qa1.size();
    run_copy(2, 5, -1, cyc, bsy);
    chk("stall_latency", 32'(cyc), 32'd21);
    chk("stall_busy_cycles", 32'(bsy), 32'd21);
    check_log(base);

    // Start during copy is ignored
    base = qa1.size();
    run_copy(-1, 0, 4, cyc, bsy);
    chk("restart_latency", 32'(cyc), 32'd16);
    check_log(base);

    // re-copy from DONE
    base = qa1.size();
    run_copy(-1, 0, -1, cyc, bsy);
    chk("recopy_latency", 32'(cyc), 32'd16);
    check_log(base);

    // reset during WRITE of word 5
    Start = 1'b1;
    step();
    Start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      if (we1 && ra1 == 4'd5) found = 1'b1;
      else step();
    end
    chk("reach_word5", 32'(found), 32'd1);
    #1;
    Rst = 1'b1;
    #1;
    chk("arst_wren", 32'(we1), 32'd0);
    chk("arst_busy", 32'(busy1), 32'd0);
    chk("arst_done", 32'(done1), 32'd0);
    chk("arst_romaddr", 32'(ra1), 32'd0);
    step();
    Rst = 1'b0;
    step();
    base = qa1.size();
    run_copy(-1, 0, -1, cyc, bsy);
    chk("post_rst_latency", 32'(cyc), 32'd16);
    check_log(base);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
